// File: rtl/sfifo_rd_stream.sv
// Read-side consumer for the single-clock FIFO: issues pops, captures memory read data
// after RLAT cycles and presents it as a valid/ready stream via a small elastic buffer.
module sfifo_rd_stream #(
  parameter  int DWIDTH = 32,
  parameter  int RLAT   = 1,
  localparam int BDEPTH = RLAT + 1,
  localparam int OW     = $clog2(BDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [OW-1:0]     occ
);

  localparam int AW = $clog2(2 * BDEPTH + 1);
  localparam int PW = $clog2(BDEPTH);
  localparam logic [PW-1:0] LAST = PW'(BDEPTH - 1);

  logic [RLAT-1:0]   pipe_q, pipe_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [DWIDTH-1:0] buf_q [BDEPTH];
  logic [AW-1:0]     inflight, credit_sum;
  logic              pop, deq, cap;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RLAT; i++) inflight = inflight + AW'(pipe_q[i]);
  end

  assign m_valid    = (occ_q != '0);
  assign m_data     = buf_q[head_q];
  assign occ        = occ_q;
  assign deq        = m_valid & m_ready;
  assign cap        = pipe_q[RLAT-1];
  // Words already in flight hold a reserved slot, so the buffer can never overflow.
  assign credit_sum = AW'(occ_q) + inflight - AW'(deq);
  assign fifo_re    = rst_n & ~flush & ~fifo_empty & (credit_sum < AW'(BDEPTH));
  assign pop        = fifo_re & ~fifo_empty;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = pop;
    for (int unsigned i = 1; i < RLAT; i++) pipe_d[i] = pipe_q[i-1];
    head_d = deq ? nxt(head_q) : head_q;
    tail_d = cap ? nxt(tail_q) : tail_q;
    occ_d  = occ_q + OW'(cap) - OW'(deq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < BDEPTH; i++) buf_q[i] <= '0;
    end else begin
      assert (occ_q <= OW'(BDEPTH));
      if (cap && !flush) buf_q[tail_q] <= mem_rdata;
      if (flush) begin
        pipe_q <= '0;
        occ_q  <= '0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        pipe_q <= pipe_d;
        occ_q  <= occ_d;
        head_q <= head_d;
        tail_q <= tail_d;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Directed bench for sfifo_rd_stream: three instances (RLAT=1,2,3) each fed by a
// counting FIFO/RAM model; expected values are hand-derived per cycle.
module tb_sfifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn [3];
  logic        fe [3];
  logic        fl [3];
  logic        mr [3];
  logic        re [3];
  logic        mv [3];
  logic [7:0]  rd [3];
  logic [7:0]  md [3];
  logic [7:0]  base [3];
  logic [7:0]  wc [3];
  logic [7:0]  mp [3][3];
  logic [1:0]  occ0, occ1;
  logic [2:0]  occ2;
  logic [31:0] occ_i [3];

  int unsigned passed = 0;
  int unsigned total  = 0;

  sfifo_rd_stream #(.DWIDTH(8), .RLAT(1)) u0 (
    .clk(clk), .rst_n(rn[0]), .fifo_empty(fe[0]), .fifo_re(re[0]), .mem_rdata(rd[0]),
    .flush(fl[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .occ(occ0));
  sfifo_rd_stream #(.DWIDTH(8), .RLAT(2)) u1 (
    .clk(clk), .rst_n(rn[1]), .fifo_empty(fe[1]), .fifo_re(re[1]), .mem_rdata(rd[1]),
    .flush(fl[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .occ(occ1));
  sfifo_rd_stream #(.DWIDTH(8), .RLAT(3)) u2 (
    .clk(clk), .rst_n(rn[2]), .fifo_empty(fe[2]), .fifo_re(re[2]), .mem_rdata(rd[2]),
    .flush(fl[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .occ(occ2));

  // Source model: popped word = running counter, returned RLAT cycles after the pop.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rn[k]) wc[k] <= base[k];
      else if (re[k] && !fe[k]) wc[k] <= wc[k] + 8'd1;
      mp[k][0] <= wc[k];
      for (int j = 1; j < 3; j++) mp[k][j] <= mp[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) rd[k] = mp[k][k];
    occ_i[0] = 32'(occ0);
    occ_i[1] = 32'(occ1);
    occ_i[2] = 32'(occ2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input int k, input logic [7:0] b);
    cyc();
    rn[k] = 1'b0; fe[k] = 1'b1; fl[k] = 1'b0; mr[k] = 1'b0; base[k] = b;
    cyc();
  endtask

  task automatic stream(input int k);
    int lat;
    lat = k + 2;
    do_rst(k, 8'd0);
    for (int n = 0; n < 16 + lat + 2; n++) begin
      cyc();
      rn[k] = 1'b1; mr[k] = 1'b1; fe[k] = (n < 16) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("stream%0d re n=%0d", k, n), 32'(re[k]), 32'(n < 16));
      if (n >= lat && n < lat + 16) begin
        chk($sformatf("stream%0d mv n=%0d", k, n), 32'(mv[k]), 32'd1);
        chk($sformatf("stream%0d md n=%0d", k, n), 32'(md[k]), 32'(n - lat));
      end else begin
        chk($sformatf("stream%0d mv n=%0d", k, n), 32'(mv[k]), 32'd0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rn[k] = 1'b0; fe[k] = 1'b1; fl[k] = 1'b0; mr[k] = 1'b0; base[k] = 8'd0;
    end

    // Reset state and single-word latency, RLAT=1
    do_rst(0, 8'hA5);
    cyc();
    fe[0] = 1'b0; mr[0] = 1'b1;
    #1;
    chk("rst re", 32'(re[0]), 32'd0);
    chk("rst mv", 32'(mv[0]), 32'd0);
    chk("rst occ", occ_i[0], 32'd0);
    chk("rst md", 32'(md[0]), 32'd0);
    cyc();
    rn[0] = 1'b1;
    #1;
    chk("lat pop", 32'(re[0]), 32'd1);
    cyc();
    fe[0] = 1'b1;
    #1;
    chk("lat mv t+1", 32'(mv[0]), 32'd0);
    chk("lat re t+1", 32'(re[0]), 32'd0);
    cyc();
    chk("lat mv t+2", 32'(mv[0]), 32'd1);
    chk("lat md t+2", 32'(md[0]), 32'hA5);
    chk("lat occ t+2", occ_i[0], 32'd1);
    cyc();
    chk("lat mv t+3", 32'(mv[0]), 32'd0);
    chk("lat occ t+3", occ_i[0], 32'd0);

    // Streaming at RLAT=1 and RLAT=3
    stream(0);
    stream(2);

    // Backpressure, RLAT=2: m_ready low for cycles 6..15
    do_rst(1, 8'd0);
    for (int n = 0; n < 26; n++) begin
      cyc();
      rn[1] = 1'b1; fe[1] = 1'b0; mr[1] = !(n >= 6 && n <= 15);
      #1;
      chk($sformatf("bp re n=%0d", n), 32'(re[1]), 32'(n < 6 || n > 15));
      chk($sformatf("bp mv n=%0d", n), 32'(mv[1]), 32'(n >= 3));
      if (n >= 3)
        chk($sformatf("bp md n=%0d", n), 32'(md[1]),
            32'((n < 6) ? n - 3 : (n <= 16) ? 3 : n - 13));
      chk($sformatf("bp occ n=%0d", n), occ_i[1],
          32'((n < 3) ? 0 : (n < 7) ? 1 : (n == 7) ? 2 : (n <= 16) ? 3 : (n == 17) ? 2 : 1));
    end

    // Source empty for cycles 5..7, RLAT=2: bubble on m_valid at 8..10
    do_rst(1, 8'd0);
    for (int n = 0; n < 17; n++) begin
      cyc();
      rn[1] = 1'b1; mr[1] = 1'b1; fe[1] = (n >= 5 && n <= 7);
      #1;
      chk($sformatf("emp re n=%0d", n), 32'(re[1]), 32'(!(n >= 5 && n <= 7)));
      chk($sformatf("emp mv n=%0d", n), 32'(mv[1]), 32'(n >= 3 && !(n >= 8 && n <= 10)));
      if (n >= 3 && !(n >= 8 && n <= 10))
        chk($sformatf("emp md n=%0d", n), 32'(md[1]), 32'((n < 8) ? n - 3 : n - 6));
    end

    // Flush with two words in flight and one buffered, RLAT=2
    do_rst(1, 8'd0);
    for (int n = 0; n < 9; n++) begin
      cyc();
      rn[1] = 1'b1; fe[1] = (n > 4); mr[1] = (n >= 3); fl[1] = (n == 3);
      #1;
      case (n)
        3: begin
          chk("fl re in flush", 32'(re[1]), 32'd0);
          chk("fl occ pre", occ_i[1], 32'd1);
          chk("fl mv pre", 32'(mv[1]), 32'd1);
        end
        4: begin
          chk("fl occ post", occ_i[1], 32'd0);
          chk("fl mv post", 32'(mv[1]), 32'd0);
          chk("fl re post", 32'(re[1]), 32'd1);
        end
        5, 6: chk($sformatf("fl mv n=%0d", n), 32'(mv[1]), 32'd0);
        7: begin
          chk("fl mv new", 32'(mv[1]), 32'd1);
          chk("fl md new", 32'(md[1]), 32'd3);
        end
        8: chk("fl mv end", 32'(mv[1]), 32'd0);
        default: ;
      endcase
    end
    fl[1] = 1'b0;

    // Reset pulse mid-stream at cycle 8, RLAT=3
    do_rst(2, 8'd0);
    for (int n = 0; n < 21; n++) begin
      cyc();
      rn[2] = (n != 8); fe[2] = 1'b0; mr[2] = 1'b1;
      #1;
      chk($sformatf("mrst re n=%0d", n), 32'(re[2]), 32'(n != 8));
      chk($sformatf("mrst mv n=%0d", n), 32'(mv[2]), 32'((n >= 4 && n <= 8) || n >= 13));
      if (n >= 4 && n <= 8)
        chk($sformatf("mrst md n=%0d", n), 32'(md[2]), 32'(n - 4));
      if (n >= 13)
        chk($sformatf("mrst md n=%0d", n), 32'(md[2]), 32'(n - 13));
      if (n == 9) begin
        chk("mrst occ", occ_i[2], 32'd0);
        chk("mrst md clr", 32'(md[2]), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
